// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// Sequences one full-add cell (two half adders plus an OR) across two
// WIDTH-bit operands, LSB first, one bit per clock.
// Optional feature macro: SERIAL_ADDER_CIN_EN adds a carry_in port that
// seeds the carry register on the accept edge.
//
// Handshake: start is sampled only in IDLE; a sampled start is the accept.
// busy is high in RUN and DONE; done is a one-cycle strobe in DONE, and
// result/carry_out are valid from that cycle until the next DONE entry.
// start is ignored while busy; nothing is queued.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             carry_in,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr;
  // Holds bits 0..WIDTH-2 of the sum; the final bit joins it on the last edge.
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_full;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             c_init;
  logic [1:0]       ha0, ha1;
  logic             s_bit, c_next;

  // Two-input half adder: {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full-add cell built from two half adders and an OR for the carry.
  always_comb begin
    ha0    = half_add(a_sr[0], b_sr[0]);
    ha1    = half_add(ha0[0], c_reg);
    s_bit  = ha1[0];
    c_next = ha0[1] | ha1[1];
  end

  assign sum_full = {s_bit, sum_sr};
  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_CIN_EN
  assign c_init = carry_in;
`else
  assign c_init = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial add, result hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= op_a;
            b_sr  <= op_b;
            c_reg <= c_init;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sr <= sum_full[WIDTH-1:1];
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          c_reg  <= c_next;
          if (last_bit) begin
            // Counter holds at WIDTH-1 rather than wrapping.
            result    <= sum_full;
            carry_out <= c_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         carry_in;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, carry_out;
  logic [W-1:0] result;
  logic [1:0]   state_dbg;

  int tests_run;
  int tests_failed;

  logic [W:0] exp_q[$];
  logic [W:0] last_res;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SERIAL_ADDER_CIN_EN
    .carry_in  (carry_in),
`endif
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .state_dbg (state_dbg)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard and checks the DONE-cycle outputs.
  task automatic check_done(input string tag);
    logic [W:0] e;
    check({tag, "_sb_pending"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, result, e[W-1:0]);
      check({tag, "_carry"}, carry_out, e[W]);
      last_res = e;
    end
  endtask

  // One full operation: accept edge E0, bits on E1..E8, done after E8,
  // idle after E9. Result must not move before done.
  task automatic add_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W:0] exp, input bit clear_ops);
    op_a     = a;
    op_b     = b;
    carry_in = cin;
    start    = 1'b1;
    exp_q.push_back(exp);
    tick();  // E0
    start = 1'b0;
    check({tag, "_busy_e0"}, busy, 1);
    check({tag, "_done_e0"}, done, 0);
    for (int i = 1; i <= W; i++) begin
      tick();
      if (clear_ops && i == 1) begin
        op_a = '0;
        op_b = '0;
      end
      check({tag, "_busy_run"}, busy, 1);
      if (i < W) begin
        check({tag, "_done_early"}, done, 0);
        check({tag, "_hold"}, {carry_out, result}, last_res);
      end else begin
        check({tag, "_done"}, done, 1);
        check_done(tag);
      end
    end
    tick();  // E9
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done_end"}, done, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_res     = '0;
    rst      = 1'b1;
    start    = 1'b0;
    carry_in = 1'b0;
    op_a     = '0;
    op_b     = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    rst = 1'b0;
    tick();

    // Basic operations.
    add_op("zero", 8'h00, 8'h00, 1'b0, 9'h000, 1'b0);
    add_op("ripple", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    add_op("capture", 8'hA5, 8'h5A, 1'b0, 9'h0FF, 1'b1);
    add_op("mixed", 8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b0);

    // start held high: accept every 10 cycles, never restarted mid-run.
    op_a  = 8'h01;
    op_b  = 8'h01;
    start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(9'h002);
    for (int c = 0; c < 30; c++) begin
      tick();
      check("held_busy", busy, (c % 10) != 9);
      check("held_done", done, (c % 10) == 8);
      if ((c % 10) == 8) check_done("held");
    end
    start = 1'b0;
    tick();
    check("held_idle", busy, 0);

    // Reset after bit 4 (edge E5) aborts the operation.
    op_a  = 8'h33;
    op_b  = 8'h44;
    start = 1'b1;
    tick();  // E0
    start = 1'b0;
    repeat (5) tick();  // E1..E5
    check("abort_busy_pre", busy, 1);
    rst = 1'b1;
    tick();  // E6 with reset
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_carry", carry_out, 0);
    last_res = '0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (done) seen++;
      end
      check("abort_no_done", seen, 0);
    end
    add_op("msb", 8'h80, 8'h80, 1'b0, 9'h100, 1'b0);

    // Reset and start on the same edge: request dropped.
    rst   = 1'b1;
    start = 1'b1;
    op_a  = 8'h11;
    op_b  = 8'h22;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", busy, 0);
    tick();
    check("rst_start_busy2", busy, 0);
    last_res = '0;

`ifdef SERIAL_ADDER_CIN_EN
    add_op("cin_7f", 8'h7F, 8'h00, 1'b1, 9'h080, 1'b0);
    add_op("cin_ff", 8'hFF, 8'h00, 1'b1, 9'h100, 1'b0);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
